// File: rtl/audio_note_sequencer.sv
// Wishbone-mapped 16-step note sequencer feeding the waveform generator's note/gate inputs.
// The CPU loads pattern, tempo and length, sets RUN, and the block plays the pattern on its own.
module audio_note_sequencer #(
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned TEMPO_W = 24
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic [4:0]  o_note,
    output logic        o_gate,
    output logic [3:0]  o_step,
    output logic        o_irq
);

    localparam int unsigned PAT_N  = 16;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned NOTE_W = 5;
    localparam logic [TEMPO_W-1:0] GAP_T = TEMPO_W'(GAP_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NOTE,
        S_GAP
    } state_e;

    state_e              state_q;
    logic [TEMPO_W-1:0]  cnt_q;
    logic [STEP_W-1:0]   step_q;
    logic [NOTE_W-1:0]   note_q;
    logic                gate_q;

    logic                ack_q;
    logic [31:0]         rdt_q, rdt_d;
    logic                run_q, run_d;
    logic                loop_q, loop_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                irq_q, irq_d;
    logic [TEMPO_W-1:0]  tempo_q, tempo_d;
    logic [STEP_W-1:0]   len_q, len_d;
    logic [7:0]          pat_q [PAT_N];

    logic                wr_c;
    logic                busy_c;
    logic                seq_end_c;
    logic                load_c;
    logic [STEP_W-1:0]   next_step_c;
    logic [7:0]          entry_c;
    logic [TEMPO_W-1:0]  tempo_eff_c;
    logic [TEMPO_W-1:0]  note_cnt_c;
    logic                unused_ok;

    assign unused_ok = ^{i_wb_sel, i_wb_adr[1:0], i_wb_dat};

    assign wr_c   = i_wb_cyc & i_wb_stb & i_wb_we & ~ack_q;
    assign busy_c = (state_q != S_IDLE);

    // Last GAP cycle of the final step of a non-looping run
    assign seq_end_c = (state_q == S_GAP) && (cnt_q == '0) && (step_q == len_q)
                       && !loop_q && run_q;

    assign load_c = run_q && ((state_q == S_IDLE) ||
                    ((state_q == S_GAP) && (cnt_q == '0) && !seq_end_c));

    // Step selection, entry fetch and NOTE-phase length (T=0 -> 1, clamp to >= 1 cycle)
    always_comb begin
        next_step_c = '0;
        if (state_q != S_IDLE && step_q != len_q) begin
            next_step_c = step_q + STEP_W'(1);
        end
        entry_c     = pat_q[next_step_c];
        tempo_eff_c = (tempo_q == '0) ? TEMPO_W'(1) : tempo_q;
        note_cnt_c  = '0;
        if (tempo_eff_c > GAP_T) begin
            note_cnt_c = tempo_eff_c - GAP_T - TEMPO_W'(1);
        end
    end

    // Control/status register next-state; hardware DONE set wins over W1C
    always_comb begin
        run_d    = run_q;
        loop_d   = loop_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        tempo_d  = tempo_q;
        len_d    = len_q;
        if (wr_c && !i_wb_adr[6]) begin
            case (i_wb_adr[5:2])
                4'd0: {irq_en_d, loop_d, run_d} = i_wb_dat[2:0];
                4'd1: if (i_wb_dat[1]) done_d = 1'b0;
                4'd2: tempo_d = i_wb_dat[TEMPO_W-1:0];
                4'd3: len_d = i_wb_dat[STEP_W-1:0];
                default: ;
            endcase
        end
        if (seq_end_c) begin
            done_d = 1'b1;
            run_d  = 1'b0;
        end
        irq_d = done_d & irq_en_d;
    end

    always_comb begin
        rdt_d = '0;
        case (i_wb_adr[6:2])
            5'd0:    rdt_d = {29'd0, irq_en_q, loop_q, run_q};
            5'd1:    rdt_d = {24'd0, step_q, 2'd0, done_q, busy_c};
            5'd2:    rdt_d = 32'(tempo_q);
            5'd3:    rdt_d = {28'd0, len_q};
            default: if (i_wb_adr[6]) rdt_d = {24'd0, pat_q[i_wb_adr[5:2]]};
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q    <= 1'b0;
            rdt_q    <= '0;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            tempo_q  <= '0;
            len_q    <= '0;
            for (int i = 0; i < PAT_N; i++) pat_q[i] <= '0;
        end else begin
            ack_q    <= i_wb_cyc & i_wb_stb & ~ack_q;
            rdt_q    <= rdt_d;
            run_q    <= run_d;
            loop_q   <= loop_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
            tempo_q  <= tempo_d;
            len_q    <= len_d;
            if (wr_c && i_wb_adr[6]) pat_q[i_wb_adr[5:2]] <= i_wb_dat[7:0];
        end
    end

    // Sequencer FSM; CPU clearing RUN aborts without touching step or DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            note_q  <= '0;
            gate_q  <= 1'b0;
        end else if (busy_c && !run_q) begin
            state_q <= S_IDLE;
            gate_q  <= 1'b0;
        end else if (load_c) begin
            state_q <= S_NOTE;
            step_q  <= next_step_c;
            cnt_q   <= note_cnt_c;
            gate_q  <= ~entry_c[7];
            if (!entry_c[7]) note_q <= entry_c[NOTE_W-1:0];
        end else if (busy_c) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - TEMPO_W'(1);
            end else if (state_q == S_NOTE) begin
                state_q <= S_GAP;
                gate_q  <= 1'b0;
                cnt_q   <= GAP_T - TEMPO_W'(1);
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_note   = note_q;
    assign o_gate   = gate_q;
    assign o_step   = step_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Scoreboard bench for audio_note_sequencer: bus reads and note events are checked by monitors
// against expectations queued by the directed stimulus.
module tb_audio_note_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic [4:0]  note;
    logic        gate;
    logic [3:0]  step;
    logic        irq;

    audio_note_sequencer #(.GAP_CYC(16), .TEMPO_W(24)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
        .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
        .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
        .o_note(note), .o_gate(gate), .o_step(step), .o_irq(irq)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int step;
        int note;
        int hi;
        int per;
    } gexp_t;

    logic [31:0] rd_q[$];
    gexp_t       g_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Read-data monitor
    int rd_n = 0;
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (wb_ack && !wb_we) begin
                if (rd_q.size() == 0) flag("rd_unexpected");
                else begin
                    e = rd_q.pop_front();
                    check($sformatf("rd_%0d", rd_n), wb_rdt, e);
                    rd_n++;
                end
            end
        end
    end

    // Note-event monitor: checks step/note at gate rise, period between rises, and high width
    initial begin
        logic  prev_g;
        int    rise_c, last_rise;
        bit    have;
        gexp_t cur;
        prev_g = 1'b0; have = 1'b0; rise_c = 0; last_rise = 0;
        cur = '{0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (gate && !prev_g) begin
                if (g_q.size() == 0) flag("gate_unexpected_rise");
                else begin
                    cur = g_q.pop_front();
                    check("ev_step", 32'(step), cur.step);
                    check("ev_note", 32'(note), cur.note);
                    if (cur.per != 0) check("ev_period", cyc_cnt - last_rise, cur.per);
                    have = 1'b1;
                end
                rise_c    = cyc_cnt;
                last_rise = cyc_cnt;
            end else if (!gate && prev_g && have) begin
                if (cur.hi != 0) check("ev_gate_high", cyc_cnt - rise_c, cur.hi);
                have = 1'b0;
            end
            prev_g = gate;
        end
    end

    task automatic bus(input logic [6:0] a, input logic [31:0] d, input logic we, input bit chk_ack);
        bit got;
        got = 1'b0;
        @(negedge clk);
        wb_adr = a; wb_dat = d; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack) begin got = 1'b1; break; end
        end
        if (!got) flag("bus_ack_timeout");
        if (chk_ack) begin
            @(negedge clk);
            check("ack_one_cycle", 32'(wb_ack), 0);
        end
        #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        bus(a, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [6:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        bus(a, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_for(input logic [3:0] s, input logic g, input int lim, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (step == s && gate == g) begin hit = 1'b1; break; end
        end
        if (!hit) flag(name);
    endtask

    task automatic push_ev(input int s, input int n, input int hi, input int per);
        gexp_t e;
        e = '{s, n, hi, per};
        g_q.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wb_adr = '0; wb_dat = '0; wb_sel = 4'hF;
        wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_gate", 32'(gate), 0);
        check("rst_note", 32'(note), 0);
        check("rst_step", 32'(step), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_ack", 32'(wb_ack), 0);
        rd(7'h04, 32'h0);
        rd(7'h00, 32'h0);

        // Register readback and unmapped address
        wr(7'h08, 32'h40);
        wr(7'h0C, 32'h3);
        wr(7'h48, 32'h0A);
        rd(7'h08, 32'h40);
        rd(7'h0C, 32'h3);
        rd(7'h48, 32'h0A);
        wr(7'h10, 32'hFFFF_FFFF);
        rd_q.push_back(32'h0);
        bus(7'h10, 32'd0, 1'b0, 1'b1);

        // One-shot, T=64: gate 48 high / 16 low, DONE after 256 cycles
        wr(7'h40, 32'h01); wr(7'h44, 32'h02); wr(7'h48, 32'h03); wr(7'h4C, 32'h04);
        push_ev(0, 1, 48, 0); push_ev(1, 2, 48, 64); push_ev(2, 3, 48, 64); push_ev(3, 4, 48, 64);
        wr(7'h00, 32'h5);
        check("start_gate_pre", 32'(gate), 0);
        @(negedge clk);
        check("start_latency", 32'(gate), 1);
        repeat (255) @(negedge clk);
        check("irq_before_done", 32'(irq), 0);
        @(negedge clk);
        check("irq_at_done", 32'(irq), 1);
        rd(7'h04, 32'h32);
        rd(7'h00, 32'h04);
        wr(7'h00, 32'h0);
        @(negedge clk);
        check("irq_masked", 32'(irq), 0);
        wr(7'h04, 32'h2);
        rd(7'h04, 32'h30);

        // Loop with a REST step
        wr(7'h08, 32'd32); wr(7'h0C, 32'd1); wr(7'h40, 32'h01); wr(7'h44, 32'h80);
        push_ev(0, 1, 16, 0); push_ev(0, 1, 16, 64);
        wr(7'h00, 32'h3);
        wait_for(4'd1, 1'b0, 200, "wait_loop_s1a");
        check("rest_note_a", 32'(note), 1);
        wait_for(4'd0, 1'b1, 200, "wait_loop_s0");
        wait_for(4'd1, 1'b0, 200, "wait_loop_s1b");
        check("rest_note_b", 32'(note), 1);
        wr(7'h00, 32'h0);
        rd(7'h04, 32'h10);

        // Abort during NOTE of step 2
        wr(7'h08, 32'd64); wr(7'h0C, 32'd3); wr(7'h44, 32'h02);
        push_ev(0, 1, 48, 0); push_ev(1, 2, 48, 64); push_ev(2, 3, 0, 64);
        wr(7'h00, 32'h1);
        wait_for(4'd2, 1'b1, 400, "wait_abort_s2");
        wr(7'h00, 32'h0);
        @(negedge clk);
        check("abort_gate", 32'(gate), 0);
        check("abort_step", 32'(step), 2);
        rd(7'h04, 32'h20);

        // DONE set and W1C on the same edge: set wins
        wr(7'h08, 32'd32); wr(7'h0C, 32'd0);
        push_ev(0, 1, 16, 0);
        wr(7'h00, 32'h1);
        repeat (31) @(negedge clk);
        wr(7'h04, 32'h2);
        rd(7'h04, 32'h02);
        rd(7'h00, 32'h0);
        wr(7'h04, 32'h2);
        rd(7'h04, 32'h00);

        // Tempo below GAP_CYC+1: 1-cycle NOTE, 17-cycle period
        wr(7'h08, 32'd5); wr(7'h0C, 32'd1); wr(7'h40, 32'h05); wr(7'h44, 32'h06);
        push_ev(0, 5, 1, 0); push_ev(1, 6, 1, 17);
        wr(7'h00, 32'h1);
        repeat (40) @(negedge clk);
        rd(7'h04, 32'h12);
        wr(7'h04, 32'h2);

        // Asynchronous reset mid-step
        wr(7'h08, 32'd64); wr(7'h0C, 32'd3);
        push_ev(0, 5, 0, 0);
        wr(7'h00, 32'h7);
        wait_for(4'd0, 1'b1, 50, "wait_rst_s0");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gate", 32'(gate), 0);
        check("arst_note", 32'(note), 0);
        check("arst_step", 32'(step), 0);
        check("arst_irq", 32'(irq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(7'h40, 32'h0);
        rd(7'h00, 32'h0);
        rd(7'h08, 32'h0);
        rd(7'h04, 32'h0);

        repeat (4) @(negedge clk);
        check("rd_queue_empty", rd_q.size(), 0);
        check("ev_queue_empty", g_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
